// File: rtl/cpu_req_queue.sv
// cpu_req_queue: in-order request buffer in front of the cache CPU port.
// Requests are queued in a small FIFO and sent to the cache one at a time.
// Each request gets exactly one response: read data, a write acknowledgement,
// or an error (reserved op, or the cache hung past the watchdog limit).
module cpu_req_queue #(
    parameter int WIDTH_A = 32,
    parameter int WIDTH_D = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // core request channel
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [WIDTH_A-1:0]       req_addr,
    input  logic [WIDTH_D-1:0]       req_wdata,
    // core response channel
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_op,
    output logic [WIDTH_D-1:0]       rsp_rdata,
    output logic                     rsp_err,
    // cache CPU port
    output logic [1:0]               cpu_request,
    output logic [WIDTH_A-1:0]       cpu_addr,
    output logic [WIDTH_D-1:0]       cpu_wdata,
    input  logic [WIDTH_D-1:0]       cpu_rdata,
    input  logic                     cache_ready,
    input  logic                     cache_complete,
    // status
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // FIFO storage and bookkeeping
    logic [1:0]         r_fop   [DEPTH];
    logic [WIDTH_A-1:0] r_faddr [DEPTH];
    logic [WIDTH_D-1:0] r_fwdata[DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    // transaction in flight
    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH_A-1:0] r_addr;
    logic [WIDTH_D-1:0] r_wdata;
    logic [WIDTH_D-1:0] r_rdata;
    logic               r_err;
    logic [1:0]         r_cpu_req;
    logic               r_rsp_valid;
    logic [WW-1:0]      r_wdog;

    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_head_op;

    // Ready comes only from the registered count: a full FIFO refuses a push
    // even if the head is being popped in the same cycle.
    assign req_ready  = (r_count < CW'(DEPTH));
    assign w_push     = req_valid && req_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_op  = r_fop[r_rptr];

    assign fifo_count  = r_count;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);
    assign cpu_request = r_cpu_req;
    assign cpu_addr    = r_addr;
    assign cpu_wdata   = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_op      = r_op;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;

    // FIFO payload storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fop[r_wptr]    <= req_op;
            r_faddr[r_wptr]  <= req_addr;
            r_fwdata[r_wptr] <= req_wdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Issue FSM: pop, send to cache, wait with watchdog, hold response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cpu_req   <= '0;
            r_rsp_valid <= 1'b0;
            r_wdog      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op    <= w_head_op;
                        r_addr  <= r_faddr[r_rptr];
                        r_wdata <= r_fwdata[r_rptr];
                        r_rdata <= '0;
                        if (w_head_op == OP_RD || w_head_op == OP_WR) begin
                            r_err     <= 1'b0;
                            r_cpu_req <= w_head_op;
                            r_state   <= S_ISSUE;
                        end else begin
                            // reserved op never reaches the cache
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cache_ready) begin
                        r_cpu_req <= '0;
                        r_wdog    <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // completion beats a timeout landing in the same cycle
                    if (cache_complete) begin
                        r_rdata     <= (r_op == OP_RD) ? cpu_rdata : '0;
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wdog == WW'(TIMEOUT - 1)) begin
                        r_rdata     <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
